sd_card_spi_word_transfer: RTL and testbench
============================================

SD_CARD_SPI_WORD_TRANSFER -- requirements
Module: sd_card_spi_word_transfer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word length in bits (legal values 8, 16 and 32).
REQ-002 SHALL have parameter DIV_W, default 8, width of the SCK half-period divisor.
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 means MSB is shifted first, 0 means LSB is shifted first.
REQ-004 SHALL have port clk210_p, input, 1 bit: the single 210 MHz clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port reset_p, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port sd_spi_div_p, input, DIV_W bits: SCK half-period is (div+1) clk210_p cycles.
REQ-007 SHALL have port sd_spi_cpol_p, input, 1 bit: SCK idle level.
REQ-008 SHALL have port sd_spi_cpha_p, input, 1 bit: 0 samples MISO on the leading edge, 1 samples on the trailing edge.
REQ-009 SHALL have port sd_spi_tx_data_p, input, DATA_W bits: word to transmit.
REQ-010 SHALL have port sd_spi_tx_valid_p, input, 1 bit: tx word offered.
REQ-011 SHALL have port sd_spi_tx_ready_p, output, 1 bit: block can accept a word.
REQ-012 SHALL have port sd_spi_rx_data_p, output, DATA_W bits: last received word.
REQ-013 SHALL have port sd_spi_rx_valid_p, output, 1 bit: one-cycle pulse marking a completed word.
REQ-014 SHALL have port sd_spi_busy_p, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port sd_spi_miso_p, input, 1 bit; port sd_spi_mosi_p, output, 1 bit; port sd_spi_sck_p, output, 1 bit. Chip select is not part of this block.

Function
REQ-016 SHALL implement states IDLE, LEAD, TRAIL and DONE.
REQ-017 SHALL accept a word on a clock edge where tx_valid and tx_ready are both high; tx_ready SHALL be high only in IDLE and DONE.
REQ-018 SHALL latch tx_data, div, cpol and cpha at accept; later input changes SHALL NOT affect the word in flight.
REQ-019 In IDLE, SHALL drive SCK equal to the live sd_spi_cpol_p value, SHALL drive MOSI to 1, and SHALL hold the rx_data value.
REQ-020 A half-period counter SHALL count 0..div, starting at 0 at accept; at count==div, SCK SHALL toggle and the counter SHALL clear.
REQ-021 Toggles SHALL alternate LEAD->TRAIL (leading edge) and TRAIL->LEAD (trailing edge), for exactly DATA_W SCK periods.
REQ-022 With CPHA=0, the first bit SHALL appear on MOSI at accept; the following bit SHALL be presented at each trailing edge except the last; MISO SHALL be sampled at each leading edge.
REQ-023 With CPHA=1, each bit SHALL be presented on MOSI at its leading edge, and MISO SHALL be sampled at each trailing edge.
REQ-024 "Sampled" SHALL mean the value of sd_spi_miso_p captured at the same clk edge on which the SCK register toggles.
REQ-025 At the final trailing edge, at clock edge E0 + 2*DATA_W*(div+1), where E0 is the accept edge:
- the block SHALL enter DONE;
- rx_data SHALL be updated with the assembled word, in MSB_FIRST order;
- rx_valid SHALL be high for exactly one cycle;
- MOSI SHALL return to 1.
REQ-026 In DONE, if tx_valid is high, the block SHALL accept the next word and go to LEAD, giving back-to-back words with one DONE cycle between them; otherwise it SHALL go to IDLE.
REQ-027 With div=0, SCK SHALL toggle every clock cycle, giving 105 MHz; no extra wait cycles SHALL be inserted.
REQ-028 Any undefined state encoding SHALL go to IDLE on the next clock.

Reset
REQ-029 While reset_p is high, the block SHALL drive: state=IDLE, SCK=0, MOSI=1, tx_ready=0, rx_valid=0, busy=0, rx_data=0, counters=0.
REQ-030 Reset asserted mid-word SHALL abort the word with no rx_valid pulse; the first clock after reset release SHALL be IDLE with tx_ready=1 and SCK=cpol.

Verification
REQ-031 Mode 0 check: DATA_W=8, div=3, cpol=0, cpha=0, tx=0xA5, MISO model returns 0x3C -> MOSI carries 10100101 on rising edges; rx_valid occurs 64 cycles after accept; rx_data=0x3C.
REQ-032 Mode 3 check: cpol=1, cpha=1, div=0, tx=0x81, MISO returns 0xFF -> SCK idles high; 8 periods of 2 cycles each; rx_data=0xFF; MOSI=1 after DONE.
REQ-033 Back-to-back check: tx_valid held high with words 0x11 then 0x22, div=1 -> second accept occurs in the DONE cycle; exactly one clock lies between the last SCK edge of word 1 and the first count of word 2; two rx_valid pulses 33 cycles apart.
REQ-034 Parameter check: DATA_W=16, MSB_FIRST=0, tx=0x0001 -> first MOSI bit is 1, followed by fifteen 0s; loopback of MOSI to MISO gives rx_data=0x0001.
REQ-035 Reset check: assert reset_p after 3 SCK periods of a word -> SCK=0 and MOSI=1 on the next clock; no rx_valid pulse; tx_ready=1 one cycle after release.
REQ-036 Latch check: change div and cpha mid-word -> word timing and sampling are unchanged; the new values apply from the next accept.

Source files
------------

// File: rtl/sd_card_spi_word_transfer_if.sv
// Bundle of the word-transfer handshake, SPI configuration and SPI pin signals.
// The master side drives configuration, tx words and MISO; the slave side is the transfer block.
interface sd_card_spi_word_transfer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 8
);
    logic [DIV_W-1:0]  sd_spi_div_p;
    logic              sd_spi_cpol_p;
    logic              sd_spi_cpha_p;
    logic [DATA_W-1:0] sd_spi_tx_data_p;
    logic              sd_spi_tx_valid_p;
    logic              sd_spi_tx_ready_p;
    logic [DATA_W-1:0] sd_spi_rx_data_p;
    logic              sd_spi_rx_valid_p;
    logic              sd_spi_busy_p;
    logic              sd_spi_miso_p;
    logic              sd_spi_mosi_p;
    logic              sd_spi_sck_p;

    modport master (
        output sd_spi_div_p, sd_spi_cpol_p, sd_spi_cpha_p, sd_spi_tx_data_p, sd_spi_tx_valid_p,
        output sd_spi_miso_p,
        input  sd_spi_tx_ready_p, sd_spi_rx_data_p, sd_spi_rx_valid_p, sd_spi_busy_p,
        input  sd_spi_mosi_p, sd_spi_sck_p
    );

    modport slave (
        input  sd_spi_div_p, sd_spi_cpol_p, sd_spi_cpha_p, sd_spi_tx_data_p, sd_spi_tx_valid_p,
        input  sd_spi_miso_p,
        output sd_spi_tx_ready_p, sd_spi_rx_data_p, sd_spi_rx_valid_p, sd_spi_busy_p,
        output sd_spi_mosi_p, sd_spi_sck_p
    );
endinterface

// File: rtl/sd_card_spi_word_transfer.sv
// SPI master that shifts one DATA_W-bit word per handshake, all four CPOL/CPHA modes,
// SCK half-period of (div+1) clk210_p cycles.
module sd_card_spi_word_transfer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DIV_W     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic                        clk210_p,
    input logic                        reset_p,
    sd_card_spi_word_transfer_if.slave sd_spi
);
    localparam int unsigned BIT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLead  = 2'd1,
        StTrail = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic              cpha_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              sck_q;
    logic              mosi_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic              in_reset_q;

    logic              tx_ready;
    logic              accept;
    logic              half_done;
    logic              last_bit;
    logic [DATA_W-1:0] rx_next;

    function automatic logic out_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // in_reset_q keeps tx_ready low and SCK at 0 until the first clock after reset release
    assign tx_ready  = (state_q == StDone) || ((state_q == StIdle) && !in_reset_q);
    assign accept    = sd_spi.sd_spi_tx_valid_p && tx_ready;
    assign half_done = (cnt_q == div_q);
    assign last_bit  = (bit_cnt_q == BIT_W'(DATA_W - 1));
    assign rx_next   = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], sd_spi.sd_spi_miso_p}
                                 : {sd_spi.sd_spi_miso_p, rx_sh_q[DATA_W-1:1]};

    always_ff @(posedge clk210_p) begin
        if (reset_p) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            cpha_q     <= 1'b0;
            bit_cnt_q  <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            in_reset_q <= 1'b1;
        end else begin
            in_reset_q <= 1'b0;
            rx_valid_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        state_q   <= StLead;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        div_q     <= sd_spi.sd_spi_div_p;
                        cpha_q    <= sd_spi.sd_spi_cpha_p;
                        sck_q     <= sd_spi.sd_spi_cpol_p;
                        rx_sh_q   <= '0;
                        // CPHA=0 puts the first bit out at accept; CPHA=1 waits for the leading edge
                        if (sd_spi.sd_spi_cpha_p) begin
                            tx_sh_q <= sd_spi.sd_spi_tx_data_p;
                            mosi_q  <= 1'b1;
                        end else begin
                            tx_sh_q <= shift_out(sd_spi.sd_spi_tx_data_p);
                            mosi_q  <= out_bit(sd_spi.sd_spi_tx_data_p);
                        end
                    end else begin
                        state_q <= StIdle;
                        mosi_q  <= 1'b1;
                    end
                end
                StLead: begin
                    if (half_done) begin
                        cnt_q   <= '0;
                        sck_q   <= ~sck_q;
                        state_q <= StTrail;
                        if (cpha_q) begin
                            mosi_q  <= out_bit(tx_sh_q);
                            tx_sh_q <= shift_out(tx_sh_q);
                        end else begin
                            rx_sh_q <= rx_next;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                StTrail: begin
                    if (half_done) begin
                        cnt_q <= '0;
                        sck_q <= ~sck_q;
                        if (cpha_q) begin
                            rx_sh_q <= rx_next;
                        end
                        if (last_bit) begin
                            state_q    <= StDone;
                            mosi_q     <= 1'b1;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= cpha_q ? rx_next : rx_sh_q;
                        end else begin
                            state_q   <= StLead;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            if (!cpha_q) begin
                                mosi_q  <= out_bit(tx_sh_q);
                                tx_sh_q <= shift_out(tx_sh_q);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sd_spi.sd_spi_tx_ready_p = tx_ready;
    assign sd_spi.sd_spi_rx_data_p  = rx_data_q;
    assign sd_spi.sd_spi_rx_valid_p = rx_valid_q;
    assign sd_spi.sd_spi_busy_p     = (state_q != StIdle);
    assign sd_spi.sd_spi_mosi_p     = mosi_q;
    assign sd_spi.sd_spi_sck_p      = (state_q == StIdle) ? (sd_spi.sd_spi_cpol_p & ~in_reset_q)
                                                          : sck_q;
endmodule

// File: tb/tb_sd_card_spi_word_transfer.sv
// Directed bench: an 8-bit MSB-first instance driven by an SPI slave model,
// and a 16-bit LSB-first instance with MOSI looped back to MISO.
module tb_sd_card_spi_word_transfer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sd_card_spi_word_transfer_if #(.DATA_W(8), .DIV_W(8))  b8 ();
    sd_card_spi_word_transfer_if #(.DATA_W(16), .DIV_W(8)) b16 ();

    sd_card_spi_word_transfer #(.DATA_W(8), .DIV_W(8), .MSB_FIRST(1'b1)) dut8 (
        .clk210_p (clk),
        .reset_p  (rst),
        .sd_spi   (b8.slave)
    );

    sd_card_spi_word_transfer #(.DATA_W(16), .DIV_W(8), .MSB_FIRST(1'b0)) dut16 (
        .clk210_p (clk),
        .reset_p  (rst),
        .sd_spi   (b16.slave)
    );

    assign b16.sd_spi_miso_p = b16.sd_spi_mosi_p;

    // SPI slave model, MSB first; reloads from slave_word whenever the master is idle
    logic [15:0] slave_word = 16'h0;
    logic [15:0] slave_sh   = 16'h0;
    logic        slave_out  = 1'b1;
    logic        slave_sck  = 1'b0;
    logic        slave_cpol = 1'b0;
    logic        slave_cpha = 1'b0;

    assign b8.sd_spi_miso_p = slave_out;

    always @(posedge clk) begin
        #2;
        slave_sck <= b8.sd_spi_sck_p;
        if (b8.sd_spi_busy_p !== 1'b1) begin
            slave_cpol <= b8.sd_spi_cpol_p;
            slave_cpha <= b8.sd_spi_cpha_p;
            if (b8.sd_spi_cpha_p === 1'b1) begin
                slave_sh  <= slave_word;
                slave_out <= 1'b1;
            end else begin
                slave_sh  <= {slave_word[14:0], 1'b0};
                slave_out <= slave_word[15];
            end
        end else if (b8.sd_spi_sck_p !== slave_sck) begin
            // shift on the trailing edge for CPHA=0, on the leading edge for CPHA=1
            if ((b8.sd_spi_sck_p != slave_cpol) == slave_cpha) begin
                slave_out <= slave_sh[15];
                slave_sh  <= {slave_sh[14:0], 1'b0};
            end
        end
    end

    // Edge monitors: values are those present just before each clock edge
    int         cyc = 0;
    int         acc_cnt = 0, acc_edge = 0, acc_prev = 0;
    int         rxv_cnt = 0, rxv_edge = 0, rxv_prev = 0;
    int         tog_cnt = 0;
    logic [7:0] mosi_cap = 8'h0, rx_last = 8'h0, rx_prev = 8'h0;
    logic       sck_prev = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        sck_prev <= b8.sd_spi_sck_p;
        if (b8.sd_spi_tx_valid_p === 1'b1 && b8.sd_spi_tx_ready_p === 1'b1) begin
            acc_prev <= acc_edge;
            acc_edge <= cyc;
            acc_cnt  <= acc_cnt + 1;
        end
        if (b8.sd_spi_rx_valid_p === 1'b1) begin
            rxv_prev <= rxv_edge;
            rxv_edge <= cyc - 1;
            rxv_cnt  <= rxv_cnt + 1;
            rx_prev  <= rx_last;
            rx_last  <= b8.sd_spi_rx_data_p;
        end
        if (b8.sd_spi_busy_p === 1'b1 && b8.sd_spi_sck_p !== sck_prev) begin
            tog_cnt <= tog_cnt + 1;
            if (b8.sd_spi_sck_p === 1'b1) mosi_cap <= {mosi_cap[6:0], b8.sd_spi_mosi_p};
        end
    end

    logic [15:0] mosi16_cap = 16'h0;
    logic        sck16_prev = 1'b0;
    int          rxv16_cnt = 0;

    always @(posedge clk) begin
        sck16_prev <= b16.sd_spi_sck_p;
        if (b16.sd_spi_rx_valid_p === 1'b1) rxv16_cnt <= rxv16_cnt + 1;
        if (b16.sd_spi_busy_p === 1'b1 && b16.sd_spi_sck_p !== sck16_prev &&
            b16.sd_spi_sck_p === 1'b1) begin
            mosi16_cap <= {mosi16_cap[14:0], b16.sd_spi_mosi_p};
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rxv(input bit use16, input int bound, input string tag);
        int i = 0;
        while (((use16 ? b16.sd_spi_rx_valid_p : b8.sd_spi_rx_valid_p) !== 1'b1) && i < bound) begin
            tick();
            i++;
        end
        check(tag, 32'(use16 ? b16.sd_spi_rx_valid_p : b8.sd_spi_rx_valid_p), 32'd1);
    endtask

    initial begin
        int t0, r0, a0, n;
        rst = 1'b1;
        b8.sd_spi_div_p = 8'd0;  b8.sd_spi_cpol_p = 1'b1;  b8.sd_spi_cpha_p = 1'b0;
        b8.sd_spi_tx_data_p = 8'h00;  b8.sd_spi_tx_valid_p = 1'b0;
        b16.sd_spi_div_p = 8'd0; b16.sd_spi_cpol_p = 1'b0; b16.sd_spi_cpha_p = 1'b0;
        b16.sd_spi_tx_data_p = 16'h0; b16.sd_spi_tx_valid_p = 1'b0;
        repeat (3) tick();

        // Reset state, with cpol=1 to show SCK is forced low
        check("rst_sck", 32'(b8.sd_spi_sck_p), 32'd0);
        check("rst_mosi", 32'(b8.sd_spi_mosi_p), 32'd1);
        check("rst_tx_ready", 32'(b8.sd_spi_tx_ready_p), 32'd0);
        check("rst_busy", 32'(b8.sd_spi_busy_p), 32'd0);
        check("rst_rx_valid", 32'(b8.sd_spi_rx_valid_p), 32'd0);
        check("rst_rx_data", 32'(b8.sd_spi_rx_data_p), 32'd0);
        check("rst16_rx_data", 32'(b16.sd_spi_rx_data_p), 32'd0);
        rst = 1'b0;
        tick();
        check("rel_tx_ready", 32'(b8.sd_spi_tx_ready_p), 32'd1);
        check("rel_sck_cpol", 32'(b8.sd_spi_sck_p), 32'd1);
        b8.sd_spi_cpol_p = 1'b0;
        tick();
        check("idle_sck_live", 32'(b8.sd_spi_sck_p), 32'd0);

        // Mode 0: div=3, tx=A5, slave returns 3C
        b8.sd_spi_div_p = 8'd3; b8.sd_spi_cpha_p = 1'b0; b8.sd_spi_tx_data_p = 8'hA5;
        slave_word = 16'h3C00; b8.sd_spi_tx_valid_p = 1'b1;
        t0 = tog_cnt; r0 = rxv_cnt;
        tick();
        b8.sd_spi_tx_valid_p = 1'b0; b8.sd_spi_tx_data_p = 8'h00;
        check("m0_busy", 32'(b8.sd_spi_busy_p), 32'd1);
        check("m0_ready_low", 32'(b8.sd_spi_tx_ready_p), 32'd0);
        check("m0_first_mosi", 32'(b8.sd_spi_mosi_p), 32'd1);
        wait_rxv(1'b0, 200, "m0_rx_valid");
        tick();
        check("m0_rx_data", 32'(b8.sd_spi_rx_data_p), 32'h3C);
        check("m0_latency", rxv_edge - acc_edge, 32'd64);
        check("m0_mosi_bits", 32'(mosi_cap), 32'hA5);
        check("m0_toggles", tog_cnt - t0, 32'd16);
        check("m0_pulse_width", 32'(b8.sd_spi_rx_valid_p), 32'd0);
        check("m0_rxv_count", rxv_cnt - r0, 32'd1);
        check("m0_mosi_idle", 32'(b8.sd_spi_mosi_p), 32'd1);
        check("m0_idle", 32'(b8.sd_spi_busy_p), 32'd0);

        // Mode 3: cpol=1, cpha=1, div=0, tx=81, slave returns FF
        b8.sd_spi_cpol_p = 1'b1; b8.sd_spi_cpha_p = 1'b1; b8.sd_spi_div_p = 8'd0;
        tick();
        check("m3_idle_sck", 32'(b8.sd_spi_sck_p), 32'd1);
        b8.sd_spi_tx_data_p = 8'h81; slave_word = 16'hFF00; b8.sd_spi_tx_valid_p = 1'b1;
        t0 = tog_cnt;
        tick();
        b8.sd_spi_tx_valid_p = 1'b0;
        wait_rxv(1'b0, 100, "m3_rx_valid");
        tick();
        check("m3_rx_data", 32'(b8.sd_spi_rx_data_p), 32'hFF);
        check("m3_latency", rxv_edge - acc_edge, 32'd16);
        check("m3_toggles", tog_cnt - t0, 32'd16);
        check("m3_mosi_bits", 32'(mosi_cap), 32'h81);
        check("m3_mosi_after", 32'(b8.sd_spi_mosi_p), 32'd1);
        check("m3_sck_after", 32'(b8.sd_spi_sck_p), 32'd1);

        // Mode 1 with div/cpha/tx_data changed mid-word
        b8.sd_spi_cpol_p = 1'b0; b8.sd_spi_cpha_p = 1'b1; b8.sd_spi_div_p = 8'd2;
        b8.sd_spi_tx_data_p = 8'h3C; slave_word = 16'h5A00; b8.sd_spi_tx_valid_p = 1'b1;
        tick();
        b8.sd_spi_tx_valid_p = 1'b0;
        repeat (10) tick();
        b8.sd_spi_div_p = 8'd0; b8.sd_spi_cpha_p = 1'b0; b8.sd_spi_tx_data_p = 8'hFF;
        wait_rxv(1'b0, 200, "latch_rx_valid");
        tick();
        check("latch_rx_data", 32'(b8.sd_spi_rx_data_p), 32'h5A);
        check("latch_latency", rxv_edge - acc_edge, 32'd48);
        check("latch_mosi_bits", 32'(mosi_cap), 32'h3C);
        b8.sd_spi_tx_data_p = 8'h96; slave_word = 16'h6900; b8.sd_spi_tx_valid_p = 1'b1;
        tick();
        b8.sd_spi_tx_valid_p = 1'b0;
        wait_rxv(1'b0, 100, "new_cfg_rx_valid");
        tick();
        check("new_cfg_latency", rxv_edge - acc_edge, 32'd16);
        check("new_cfg_rx_data", 32'(b8.sd_spi_rx_data_p), 32'h69);
        check("new_cfg_mosi_bits", 32'(mosi_cap), 32'h96);

        // Back-to-back: 11 then 22 with tx_valid held, div=1
        b8.sd_spi_div_p = 8'd1; b8.sd_spi_tx_data_p = 8'h11; slave_word = 16'hC396;
        b8.sd_spi_tx_valid_p = 1'b1;
        t0 = tog_cnt; a0 = acc_cnt;
        tick();
        b8.sd_spi_tx_data_p = 8'h22;
        wait_rxv(1'b0, 100, "b2b_rx_valid_1");
        check("b2b_ready_in_done", 32'(b8.sd_spi_tx_ready_p), 32'd1);
        tick();
        b8.sd_spi_tx_valid_p = 1'b0;
        check("b2b_busy", 32'(b8.sd_spi_busy_p), 32'd1);
        wait_rxv(1'b0, 100, "b2b_rx_valid_2");
        tick();
        check("b2b_accepts", acc_cnt - a0, 32'd2);
        check("b2b_accept_gap", acc_edge - acc_prev, 32'd33);
        check("b2b_done_to_accept", acc_edge - rxv_prev, 32'd1);
        check("b2b_rxv_gap", rxv_edge - rxv_prev, 32'd33);
        check("b2b_rx_first", 32'(rx_prev), 32'hC3);
        check("b2b_rx_second", 32'(rx_last), 32'h96);
        check("b2b_mosi_bits", 32'(mosi_cap), 32'h22);
        check("b2b_toggles", tog_cnt - t0, 32'd32);

        // Reset in the middle of a word, 3.5 SCK periods in
        b8.sd_spi_tx_data_p = 8'h0F; slave_word = 16'h0; b8.sd_spi_tx_valid_p = 1'b1;
        t0 = tog_cnt; r0 = rxv_cnt;
        tick();
        b8.sd_spi_tx_valid_p = 1'b0;
        n = 0;
        while (tog_cnt - t0 < 7 && n < 100) begin
            tick();
            n++;
        end
        check("mid_toggles", tog_cnt - t0, 32'd7);
        check("mid_pre_sck", 32'(b8.sd_spi_sck_p), 32'd1);
        check("mid_pre_mosi", 32'(b8.sd_spi_mosi_p), 32'd0);
        rst = 1'b1; b8.sd_spi_cpol_p = 1'b1;
        tick();
        check("mid_rst_sck", 32'(b8.sd_spi_sck_p), 32'd0);
        check("mid_rst_mosi", 32'(b8.sd_spi_mosi_p), 32'd1);
        check("mid_rst_busy", 32'(b8.sd_spi_busy_p), 32'd0);
        check("mid_rst_rx_data", 32'(b8.sd_spi_rx_data_p), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rel_tx_ready", 32'(b8.sd_spi_tx_ready_p), 32'd1);
        check("mid_rel_sck", 32'(b8.sd_spi_sck_p), 32'd1);
        repeat (40) tick();
        check("mid_no_rx_valid", rxv_cnt - r0, 32'd0);

        // 16-bit LSB-first with loopback
        b16.sd_spi_div_p = 8'd2; b16.sd_spi_tx_data_p = 16'h0001; b16.sd_spi_tx_valid_p = 1'b1;
        tick();
        b16.sd_spi_tx_valid_p = 1'b0;
        check("p16_first_mosi", 32'(b16.sd_spi_mosi_p), 32'd1);
        wait_rxv(1'b1, 400, "p16_rx_valid");
        tick();
        check("p16_rx_data", 32'(b16.sd_spi_rx_data_p), 32'h0001);
        check("p16_mosi_bits", 32'(mosi16_cap), 32'h8000);
        check("p16_rxv_count", rxv16_cnt, 32'd1);
        check("p16_mosi_idle", 32'(b16.sd_spi_mosi_p), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
